// File: rtl/fpu_cmd_issuer.sv
// fpu_cmd_issuer: buffers core FPU commands and issues them to FPU_top one at a time, returning reg_lo/reg_hi.
module fpu_cmd_issuer #(
  parameter int OP_W        = 5,
  parameter int DATA_W      = 32,
  parameter int FPU_LATENCY = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [OP_W-1:0]   fpu_op_mask,
  output logic              fpu_instr_received,
  output logic [DATA_W-1:0] fpu_input_1,
  output logic [DATA_W-1:0] fpu_input_2,
  input  logic [DATA_W-1:0] fpu_reg_lo,
  input  logic [DATA_W-1:0] fpu_reg_hi,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [DATA_W-1:0] rsp_hi,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [OP_W-1:0]   op_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] a_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] b_mem  [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0] cnt;
  logic full, empty, push, pop;
  // extra pointer bit distinguishes full from empty
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign cmd_ready = !full;
  assign push = cmd_valid && !full;
  assign fpu_instr_received = state == ISSUE;
  assign rsp_valid = state == HOLD;
  assign busy = state != IDLE || !empty;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_nx = empty ? IDLE : ISSUE;
      end
      ISSUE: state_nx = WAIT;
      WAIT: state_nx = cnt == 8'd0 ? HOLD : WAIT;
      HOLD: begin
        pop = rsp_ready && !empty;
        state_nx = !rsp_ready ? HOLD : empty ? IDLE : ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr[AW-1:0]] <= cmd_op;
      a_mem[wr_ptr[AW-1:0]]  <= cmd_a;
      b_mem[wr_ptr[AW-1:0]]  <= cmd_b;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      fpu_op_mask <= '0;
      fpu_input_1 <= '0;
      fpu_input_2 <= '0;
      rsp_lo      <= '0;
      rsp_hi      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        fpu_op_mask <= op_mem[rd_ptr[AW-1:0]];
        fpu_input_1 <= a_mem[rd_ptr[AW-1:0]];
        fpu_input_2 <= b_mem[rd_ptr[AW-1:0]];
      end
      cnt <= state == ISSUE ? 8'(FPU_LATENCY - 1) : (state == WAIT && cnt != 8'd0) ? cnt - 1'b1 : cnt;
      if (state == WAIT && cnt == 8'd0) begin
        rsp_lo <= fpu_reg_lo;
        rsp_hi <= fpu_reg_hi;
      end
    end
  end
endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// tb_fpu_cmd_issuer: directed bench with a latency-accurate FPU_top stand-in driving reg_lo/reg_hi.
module tb_fpu_cmd_issuer;
  localparam int L = 10;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_valid2 = 1'b0, rsp_ready = 1'b1;
  logic [4:0] cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic cmd_ready, fpu_instr_received, rsp_valid, busy;
  logic [4:0] fpu_op_mask;
  logic [31:0] fpu_input_1, fpu_input_2, rsp_lo, rsp_hi;
  logic [31:0] fpu_reg_lo = '0, fpu_reg_hi = '0;
  logic cmd_ready2, instr2, rsp_valid2, busy2;
  logic [4:0] op2;
  logic [31:0] in1_2, in2_2, rsp_lo2, rsp_hi2;
  logic [31:0] lo2 = '0, hi2 = '0;
  int cyc = 0, n_cmp = 0, n_bad = 0, hold_pulse = 0, unstable = 0;
  int pulse_q[$], rise_q[$];
  logic [31:0] rsp_q[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_lo = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'hbf000000, 32'h43fa2000}: return 32'hc37a2000;
      {32'h410e147b, 32'h42814af5}: return 32'h440f83d8;
      {32'h3e05c28f, 32'h447a0000}: return 32'h4302999a;
      {32'h7f800000, 32'h00000000}: return 32'h7f800001;
      {32'h7f800100, 32'h3fc00000}: return 32'h7f800100;
      default: return a == 32'h3f800000 ? b : 32'h0bad0bad;
    endcase
  endfunction

  // FPU stand-in: outputs junk until exactly L cycles after the pulse
  logic [31:0] fres = '0;
  int fk = 0;
  always @(posedge clk) begin
    if (fpu_instr_received) begin
      fres <= fmul_ref(fpu_input_1, fpu_input_2);
      fk <= L - 1;
      {fpu_reg_hi, fpu_reg_lo} <= {JUNK, JUNK};
    end else if (fk > 0) begin
      fk <= fk - 1;
      if (fk == 1) {fpu_reg_hi, fpu_reg_lo} <= {~fres, fres};
    end
  end
  always @(posedge clk)
    {hi2, lo2} <= instr2 ? {~fmul_ref(in1_2, in2_2), fmul_ref(in1_2, in2_2)} : {JUNK, JUNK};

  fpu_cmd_issuer #(.OP_W(5), .DATA_W(32), .FPU_LATENCY(L), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .fpu_op_mask(fpu_op_mask),
    .fpu_instr_received(fpu_instr_received), .fpu_input_1(fpu_input_1), .fpu_input_2(fpu_input_2),
    .fpu_reg_lo(fpu_reg_lo), .fpu_reg_hi(fpu_reg_hi), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .busy(busy));

  fpu_cmd_issuer #(.OP_W(5), .DATA_W(32), .FPU_LATENCY(1), .FIFO_DEPTH(4)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .fpu_op_mask(op2),
    .fpu_instr_received(instr2), .fpu_input_1(in1_2), .fpu_input_2(in2_2),
    .fpu_reg_lo(lo2), .fpu_reg_hi(hi2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo2), .rsp_hi(rsp_hi2), .busy(busy2));

  always @(negedge clk) begin
    if (fpu_instr_received) begin
      pulse_q.push_back(cyc);
      if (rsp_valid) hold_pulse++;
    end
    if (rsp_valid && !prev_v) rise_q.push_back(cyc);
    if (rsp_valid && prev_v && !prev_r && rsp_lo !== prev_lo) unstable++;
    if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_lo);
    prev_v = rsp_valid;
    prev_r = rsp_ready;
    prev_lo = rsp_lo;
  end

  task automatic push_cmd(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int acc);
    int t;
    t = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    acc = cyc;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL push_timeout: cmd_ready=%b want 1", cmd_ready); end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (rsp_q.size() < n && t < 500) begin @(negedge clk); #1; t++; end
    n_cmp++;
    if (rsp_q.size() < n) begin n_bad++; $display("FAIL rsp_timeout: got %0d responses want %0d", rsp_q.size(), n); end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    pulse_q.delete(); rise_q.delete(); rsp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    if (fpu_instr_received !== 1'b0) begin n_bad++; $display("FAIL rst_instr: got %b want 0", fpu_instr_received); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if ({fpu_op_mask, fpu_input_1, fpu_input_2, rsp_lo, rsp_hi} !== '0) begin
      n_bad++; $display("FAIL rst_data: op=%h in1=%h in2=%h lo=%h hi=%h want all 0", fpu_op_mask, fpu_input_1, fpu_input_2, rsp_lo, rsp_hi);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    int acc;
    settle();
    rsp_ready = 1'b1;
    push_cmd(5'd2, 32'h3f800000, 32'h3f800000, acc);
    wait_rsp(1);
    n_cmp += 6;
    if (pulse_q.size() !== 1) begin n_bad++; $display("FAIL single_pulse_count: got %0d want 1", pulse_q.size()); end
    if (pulse_q[0] !== acc + 2) begin n_bad++; $display("FAIL single_pulse_cycle: got %0d want %0d", pulse_q[0], acc + 2); end
    if (rise_q[0] !== pulse_q[0] + L + 1) begin n_bad++; $display("FAIL single_rsp_cycle: got %0d want %0d", rise_q[0], pulse_q[0] + L + 1); end
    if (rsp_lo !== 32'h3f800000) begin n_bad++; $display("FAIL single_lo: got %h want 3f800000", rsp_lo); end
    if (rsp_hi !== 32'hc07fffff) begin n_bad++; $display("FAIL single_hi: got %h want c07fffff", rsp_hi); end
    @(negedge clk);
    if (fpu_op_mask !== 5'd2 || fpu_input_1 !== 32'h3f800000) begin
      n_bad++; $display("FAIL single_retain: op=%h in1=%h want 02 3f800000", fpu_op_mask, fpu_input_1);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    logic [31:0] want [3];
    want = '{32'hc37a2000, 32'h440f83d8, 32'h4302999a};
    settle();
    push_cmd(5'd2, 32'hbf000000, 32'h43fa2000, acc);
    push_cmd(5'd2, 32'h410e147b, 32'h42814af5, acc);
    push_cmd(5'd2, 32'h3e05c28f, 32'h447a0000, acc);
    wait_rsp(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rsp_q[i] !== want[i]) begin n_bad++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rsp_q[i], want[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (pulse_q[i] - pulse_q[i-1] !== L + 2) begin
        n_bad++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, pulse_q[i] - pulse_q[i-1], L + 2);
      end
    end
  endtask

  task automatic test_full();
    int acc;
    logic [31:0] v [6];
    v = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000, 32'h40c00000, 32'h40e00000};
    settle();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(5'd2, 32'h3f800000, v[i], acc);
    cmd_b = v[5]; cmd_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
    repeat (20) @(negedge clk);
    #1;
    n_cmp += 6;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_held: got %b want 0", cmd_ready); end
    if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL full_rsp_valid: got %b want 1", rsp_valid); end
    if (pulse_q.size() !== 1) begin n_bad++; $display("FAIL full_pulses: got %0d want 1", pulse_q.size()); end
    if (rsp_lo !== v[0]) begin n_bad++; $display("FAIL full_lo: got %h want %h", rsp_lo, v[0]); end
    if (unstable !== 0) begin n_bad++; $display("FAIL full_stable: got %0d changes want 0", unstable); end
    if (hold_pulse !== 0) begin n_bad++; $display("FAIL full_hold_pulse: got %0d want 0", hold_pulse); end
    @(posedge clk); #1 rsp_ready = 1'b1;
    push_cmd(5'd2, 32'h3f800000, v[5], acc);
    wait_rsp(6);
    repeat (30) @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_q.size() !== 6) begin n_bad++; $display("FAIL full_count: got %0d want 6", rsp_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rsp_q[i] !== v[i]) begin n_bad++; $display("FAIL full_rsp%0d: got %h want %h", i, rsp_q[i], v[i]); end
    end
  endtask

  task automatic test_special();
    int acc;
    settle();
    push_cmd(5'd2, 32'h7f800000, 32'h00000000, acc);
    push_cmd(5'd2, 32'h7f800100, 32'h3fc00000, acc);
    wait_rsp(2);
    n_cmp += 5;
    if (rsp_q[0] !== 32'h7f800001) begin n_bad++; $display("FAIL inf_x_zero: got %h want 7f800001", rsp_q[0]); end
    if (rsp_q[1] !== 32'h7f800100) begin n_bad++; $display("FAIL nan_prop: got %h want 7f800100", rsp_q[1]); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_at_hs: got %b want 1", busy); end
    @(negedge clk);
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_hs: got %b want 0", busy); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL valid_after_hs: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_wait();
    int acc, t, p0, r0;
    settle();
    push_cmd(5'd2, 32'h3f800000, 32'h41000000, acc);
    t = 0;
    while (pulse_q.size() == 0 && t < 50) begin @(negedge clk); #1; t++; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    p0 = pulse_q.size(); r0 = rise_q.size();
    @(negedge clk);
    n_cmp += 4;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstw_ready: got %b want 1", cmd_ready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstw_busy: got %b want 0", busy); end
    repeat (20) @(negedge clk);
    #1;
    if (rise_q.size() !== r0) begin n_bad++; $display("FAIL rstw_no_rsp: got %0d rises want %0d", rise_q.size(), r0); end
    if (pulse_q.size() !== p0) begin n_bad++; $display("FAIL rstw_no_pulse: got %0d pulses want %0d", pulse_q.size(), p0); end
    rsp_q.delete(); pulse_q.delete();
    @(posedge clk); #1;
    push_cmd(5'd3, 32'h3f800000, 32'h41200000, acc);
    wait_rsp(1);
    n_cmp += 2;
    if (rsp_q[0] !== 32'h41200000) begin n_bad++; $display("FAIL rstw_next_lo: got %h want 41200000", rsp_q[0]); end
    if (pulse_q[0] !== acc + 2) begin n_bad++; $display("FAIL rstw_next_pulse: got %0d want %0d", pulse_q[0], acc + 2); end
  endtask

  task automatic test_lat1();
    int acc, n, t;
    settle();
    cmd_a = 32'hbf000000; cmd_b = 32'h43fa2000; cmd_valid2 = 1'b1;
    @(negedge clk);
    acc = cyc;
    n_cmp++;
    if (cmd_ready2 !== 1'b1) begin n_bad++; $display("FAIL l1_ready: got %b want 1", cmd_ready2); end
    @(posedge clk); #1 cmd_valid2 = 1'b0;
    t = 0;
    while (!instr2 && t < 20) begin @(negedge clk); t++; end
    n = cyc;
    n_cmp++;
    if (n !== acc + 2 || instr2 !== 1'b1) begin n_bad++; $display("FAIL l1_pulse: got cycle %0d want %0d", n, acc + 2); end
    t = 0;
    while (!rsp_valid2 && t < 20) begin @(negedge clk); t++; end
    n_cmp += 3;
    if (cyc !== n + 2 || rsp_valid2 !== 1'b1) begin n_bad++; $display("FAIL l1_rsp_cycle: got %0d want %0d", cyc, n + 2); end
    if (rsp_lo2 !== 32'hc37a2000) begin n_bad++; $display("FAIL l1_lo: got %h want c37a2000", rsp_lo2); end
    if (rsp_hi2 !== 32'h3c85dfff) begin n_bad++; $display("FAIL l1_hi: got %h want 3c85dfff", rsp_hi2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_special();
    test_reset_mid_wait();
    test_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
